aes_sub_bytes: RTL and testbench

AES_SUB_BYTES -- requirements
Module: aes_sub_bytes

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_sbox.sv | 21 ++
 rtl/aes_sub_bytes.sv | 60 ++++++
 tb/tb_aes_sub_bytes.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and FIPS-197 substitution tables.
// Contents: aes_state_t (128-bit state), aes_byte_t (one byte),
//           SBOX (forward table), INV_SBOX (inverse table, only with AES_SUBBYTES_INV_EN).
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    localparam int unsigned STATE_BYTES = 16;

    // Forward S-box, indexed by input byte value.
    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef AES_SUBBYTES_INV_EN
    // Inverse S-box, indexed by input byte value.
    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`endif

endpackage

// File: rtl/aes_sbox.sv
// Single-byte S-box lookup (pure combinational table read).
// Ports: byte_in  - byte to substitute
//        inv      - 1 selects inverse table (only with AES_SUBBYTES_INV_EN)
//        byte_out_c - substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  aes_byte_t byte_in,
`ifdef AES_SUBBYTES_INV_EN
    input  logic      inv,
`endif
    output aes_byte_t byte_out_c
);

`ifdef AES_SUBBYTES_INV_EN
    assign byte_out_c = inv ? INV_SBOX[byte_in] : SBOX[byte_in];
`else
    assign byte_out_c = SBOX[byte_in];
`endif

endmodule

// File: rtl/aes_sub_bytes.sv
// AES SubBytes: 16 parallel S-box lookups with optional one-cycle output register.
// Parameter: OUT_REG - 1 registers the result (latency 1), 0 passes it through combinationally.
// Macro:     AES_SUBBYTES_INV_EN - adds the inv port and the inverse table.
// Ports: clk, rst_n (async active-low), in_valid, state_in[127:0], inv (optional),
//        out_valid, state_out[127:0]. Byte k sits at bits [127-8k -: 8].
module aes_sub_bytes
    import aes_pkg::*;
#(
    parameter int unsigned OUT_REG = 1
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  aes_state_t state_in,
`ifdef AES_SUBBYTES_INV_EN
    input  logic       inv,
`endif
    output logic       out_valid,
    output aes_state_t state_out
);

    aes_state_t sub_c;

    // One lookup per byte lane; lanes never cross.
    for (genvar k = 0; k < int'(STATE_BYTES); k++) begin : g_byte
        aes_sbox u_sbox (
            .byte_in    (state_in[127-8*k -: 8]),
`ifdef AES_SUBBYTES_INV_EN
            .inv        (inv),
`endif
            .byte_out_c (sub_c[127-8*k -: 8])
        );
    end

    if (OUT_REG != 0) begin : g_reg
        aes_state_t state_q;
        logic       valid_q;

        // Result register: loads only on valid input, otherwise holds.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    state_q <= sub_c;
                end
            end
        end

        assign state_out = state_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        assign state_out = sub_c;
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_aes_sub_bytes.sv
// Directed bench for aes_sub_bytes: a registered instance (OUT_REG=1) and a
// combinational instance (OUT_REG=0) share the same stimulus.
module tb_aes_sub_bytes;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] state_in;
    logic         out_valid_r;
    logic [127:0] state_out_r;
    logic         out_valid_c;
    logic [127:0] state_out_c;
`ifdef AES_SUBBYTES_INV_EN
    logic         inv;
`endif

    int n_vec;
    int n_err;

    aes_sub_bytes #(.OUT_REG(1)) dut_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .state_in  (state_in),
`ifdef AES_SUBBYTES_INV_EN
        .inv       (inv),
`endif
        .out_valid (out_valid_r),
        .state_out (state_out_r)
    );

    aes_sub_bytes #(.OUT_REG(0)) dut_comb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .state_in  (state_in),
`ifdef AES_SUBBYTES_INV_EN
        .inv       (inv),
`endif
        .out_valid (out_valid_c),
        .state_out (state_out_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        state_in = '0;
        #12;
        n_vec++;
        if (out_valid_r !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b expected 0", out_valid_r);
        end
        n_vec++;
        if (state_out_r !== 128'h0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected 0", state_out_r);
        end
        // Combinational path ignores reset.
        n_vec++;
        if (state_out_c !== 128'h63636363636363636363636363636363 || out_valid_c !== 1'b1) begin
            n_err++;
            $display("FAIL reset_comb: got %h/%b expected 6363..63/1", state_out_c, out_valid_c);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_vectors();
        logic [127:0] vin  [6];
        logic [127:0] vexp [6];
        vin[0] = 128'h00000000000000000000000000000000; vexp[0] = 128'h63636363636363636363636363636363;
        vin[1] = 128'h000102030405060708090a0b0c0d0e0f; vexp[1] = 128'h637c777bf26b6fc53001672bfed7ab76;
        vin[2] = 128'hffffffffffffffffffffffffffffffff; vexp[2] = 128'h16161616161616161616161616161616;
        vin[3] = 128'h00000000005300000000000000000000; vexp[3] = 128'h6363636363ed63636363636363636363;
        vin[4] = 128'h193de3bea0f4e22b9ac68d2ae9f84808; vexp[4] = 128'hd42711aee0bf98f1b8b45de51e415230;
        vin[5] = 128'h101112131415161718191a1b1c1d1e1f; vexp[5] = 128'hca82c97dfa5947f0add4a2af9ca472c0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            state_in = vin[i];
            #1;
            n_vec++;
            if (state_out_c !== vexp[i] || out_valid_c !== 1'b1) begin
                n_err++;
                $display("FAIL comb_vec%0d: got %h/%b expected %h/1", i, state_out_c, out_valid_c, vexp[i]);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (state_out_r !== vexp[i] || out_valid_r !== 1'b1) begin
                n_err++;
                $display("FAIL reg_vec%0d: got %h/%b expected %h/1", i, state_out_r, out_valid_r, vexp[i]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid_c !== 1'b0) begin
            n_err++;
            $display("FAIL comb_idle_valid: got %b expected 0", out_valid_c);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vin  [3];
        logic [127:0] vexp [3];
        vin[0] = 128'h0;                                    vexp[0] = 128'h63636363636363636363636363636363;
        vin[1] = 128'h000102030405060708090a0b0c0d0e0f;     vexp[1] = 128'h637c777bf26b6fc53001672bfed7ab76;
        vin[2] = 128'hffffffffffffffffffffffffffffffff;     vexp[2] = 128'h16161616161616161616161616161616;
        @(negedge clk);
        in_valid = 1'b1;
        state_in = vin[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i < 2) state_in = vin[i+1];
            else begin
                in_valid = 1'b0;
                state_in = 128'h0123456789abcdef0123456789abcdef;
            end
            n_vec++;
            if (state_out_r !== vexp[i] || out_valid_r !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_%0d: got %h/%b expected %h/1", i, state_out_r, out_valid_r, vexp[i]);
            end
        end
        for (int j = 0; j < 2; j++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (state_out_r !== vexp[2] || out_valid_r !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_hold%0d: got %h/%b expected %h/0", j, state_out_r, out_valid_r, vexp[2]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1;
        state_in = 128'hffffffffffffffffffffffffffffffff;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid_r !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre_valid: got %b expected 1", out_valid_r);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (state_out_r !== 128'h0 || out_valid_r !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async_clear: got %h/%b expected 0/0", state_out_r, out_valid_r);
        end
        // Input stays valid across an edge while in reset; nothing may get through.
        @(posedge clk);
        #1;
        n_vec++;
        if (state_out_r !== 128'h0 || out_valid_r !== 1'b0) begin
            n_err++;
            $display("FAIL mid_held_in_reset: got %h/%b expected 0/0", state_out_r, out_valid_r);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid_r !== 1'b0 || state_out_r !== 128'h0) begin
            n_err++;
            $display("FAIL post_reset_idle: got %h/%b expected 0/0", state_out_r, out_valid_r);
        end
        @(negedge clk);
        in_valid = 1'b1;
        state_in = 128'h000102030405060708090a0b0c0d0e0f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_vec++;
        if (state_out_r !== 128'h637c777bf26b6fc53001672bfed7ab76 || out_valid_r !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_first: got %h/%b expected 637c..76/1", state_out_r, out_valid_r);
        end
    endtask

`ifdef AES_SUBBYTES_INV_EN
    task automatic test_inv();
        @(negedge clk);
        inv      = 1'b1;
        in_valid = 1'b1;
        state_in = 128'h637c777bf26b6fc53001672bfed7ab76;
        @(posedge clk);
        #1;
        n_vec++;
        if (state_out_r !== 128'h000102030405060708090a0b0c0d0e0f || out_valid_r !== 1'b1) begin
            n_err++;
            $display("FAIL inv_vec: got %h/%b expected 0001..0f/1", state_out_r, out_valid_r);
        end
        @(negedge clk);
        state_in = 128'h16161616161616161616161616161616;
        @(posedge clk);
        #1;
        n_vec++;
        if (state_out_r !== 128'hffffffffffffffffffffffffffffffff) begin
            n_err++;
            $display("FAIL inv_ff: got %h expected ff..ff", state_out_r);
        end
        @(negedge clk);
        inv      = 1'b0;
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        n_vec    = 0;
        n_err    = 0;
        in_valid = 1'b0;
        state_in = '0;
`ifdef AES_SUBBYTES_INV_EN
        inv      = 1'b0;
`endif
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid();
`ifdef AES_SUBBYTES_INV_EN
        test_inv();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
